// File: rtl/eff_pkg.sv
// eff_pkg: sample type, echo FSM states and saturation helpers shared by the effect stages.
package eff_pkg;
    typedef logic signed [15:0] sample_t;
    typedef enum logic [2:0] {CLEAR, IDLE, READ, WAIT, MIX, WRITE} echo_state_t;
    localparam sample_t SAT_MAX = 16'sh7FFF;
    localparam sample_t SAT_MIN = 16'sh8000;
    function automatic sample_t sat17(input logic signed [16:0] v);
        return (v[16] != v[15]) ? (v[16] ? SAT_MIN : SAT_MAX) : sample_t'(v[15:0]);
    endfunction
endpackage

// File: rtl/echo_ram.sv
// echo_ram: single-port delay-line RAM with one-cycle read latency; no array reset so it maps to block RAM.
module echo_ram #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);
    logic [15:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
        else    rdata <= mem[addr];
endmodule

// File: rtl/eff_echo.sv
// eff_echo: feedback echo stage; mixes each sample with a decayed copy from DEPTH samples earlier.
module eff_echo
    import eff_pkg::*;
#(
    parameter int clock_max = 25_000_000,
    parameter int DEPTH     = 4096,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic        data_ready,
    input  logic [15:0] audio_in,
    input  logic        enable,
    input  logic [2:0]  decay_shift,
    output logic [15:0] audio_out,
    output logic        process_status,
    output logic        busy,
    output logic        overrun
);
    if (clock_max <= 0 || DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("eff_echo: DEPTH must be a power of two >= 16 and clock_max positive");
    end

    echo_state_t       state;
    logic [ADDR_W-1:0] clr_addr, ptr, addr;
    sample_t           x, y, rdata, d_shift, mix, wdata;
    logic signed [16:0] sum;
    logic              en_q, we;
    logic [2:0]        ds_q;

    always_comb begin
        d_shift = rdata >>> ds_q;
        sum     = {x[15], x} + {d_shift[15], d_shift};
        mix     = en_q ? sat17(sum) : x;
        we      = (state == CLEAR) || (state == WRITE);
        addr    = (state == CLEAR) ? clr_addr : ptr;
        wdata   = (state == WRITE) ? y : '0;
    end

    echo_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk_25mhz),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            state          <= CLEAR;
            clr_addr       <= '0;
            ptr            <= '0;
            audio_out      <= '0;
            process_status <= 1'b0;
            busy           <= 1'b1;
            overrun        <= 1'b0;
            x              <= '0;
            y              <= '0;
            en_q           <= 1'b0;
            ds_q           <= '0;
        end else begin
            process_status <= 1'b0;
            if (data_ready && state != IDLE && state != CLEAR) overrun <= 1'b1;
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: if (data_ready) begin
                    x     <= audio_in;
                    en_q  <= enable;
                    ds_q  <= decay_shift;
                    busy  <= 1'b1;
                    state <= READ;
                end
                READ: state <= WAIT;
                WAIT: state <= MIX;
                MIX: begin
                    y     <= mix;
                    state <= WRITE;
                end
                WRITE: begin
                    audio_out      <= y;
                    process_status <= 1'b1;
                    ptr            <= ptr + 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule
